// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : memory_stage
//  Description : OTTER pipeline Memory stage. Issues loads/stores to data
//                memory over a REQ/ACK handshake, formats load data and store
//                byte-enables, stalls upstream while busy, and holds the
//                Memory/Writeback register.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_stage (
  input  logic        MEMORY_CLOCK,
  input  logic        MEMORY_RESET,
  input  logic [31:0] EXEC_PC_4,
  input  logic [31:0] EXEC_PC_MEM,
  input  logic [31:0] EXEC_ALU_RESULT,
  input  logic [31:0] EXEC_RS2,
  input  logic [1:0]  EXEC_RF_WR_SEL,
  input  logic        EXEC_REGWRITE,
  input  logic        EXEC_MEMWRITE,
  input  logic        EXEC_MEMREAD2,
  input  logic [2:0]  EXEC_FUNCT3,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BE,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic        MEM_STALL,
  output logic [31:0] MEM_PC_4,
  output logic [31:0] MEM_PC_MEM,
  output logic [31:0] MEM_ALU_RESULT,
  output logic [31:0] MEM_LOAD_DATA,
  output logic [1:0]  MEM_RF_WR_SEL,
  output logic        MEM_REGWRITE,
  output logic        MEM_MISALIGN
);

  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] dmem_addr_q, dmem_wdata_q;
  logic [3:0]  dmem_be_q;
  logic        dmem_req_q, dmem_we_q;
  logic [31:0] pc4_q, pc4_d, pcmem_q, pcmem_d, alu_q, alu_d, load_q, load_d;
  logic [1:0]  rfsel_q, rfsel_d;
  logic        regwr_q, regwr_d, mis_q, mis_d;

  logic        w_mem_op, w_is_byte, w_is_half, w_misalign, w_issue, w_done;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load_fmt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_mem_op  = EXEC_MEMREAD2 | EXEC_MEMWRITE;
  assign w_lane    = EXEC_ALU_RESULT[1:0];
  assign w_is_byte = (EXEC_FUNCT3[1:0] == 2'b00);
  assign w_is_half = (EXEC_FUNCT3[1:0] == 2'b01);

  // Access decode: misalignment, store lane placement and load extraction.
  // Any funct3 size code other than byte/half is handled as a word access.
  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = EXEC_RS2;
    if (w_is_byte) begin
      w_be    = 4'b0001 << w_lane;
      w_wdata = {4{EXEC_RS2[7:0]}};
    end else if (w_is_half) begin
      w_misalign = w_lane[0];
      w_be       = 4'b0011 << w_lane;
      w_wdata    = {2{EXEC_RS2[15:0]}};
    end else begin
      w_misalign = |w_lane;
    end
    case (w_lane)
      2'd0:    w_byte = DMEM_RDATA[7:0];
      2'd1:    w_byte = DMEM_RDATA[15:8];
      2'd2:    w_byte = DMEM_RDATA[23:16];
      default: w_byte = DMEM_RDATA[31:24];
    endcase
    w_half = w_lane[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
    case (EXEC_FUNCT3)
      3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_fmt = {24'd0, w_byte};
      3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_fmt = {16'd0, w_half};
      default: w_load_fmt = DMEM_RDATA;
    endcase
  end

  // Handshake FSM next state, stall, and Memory/Writeback register next value.
  always_comb begin
    state_d   = state_q;
    MEM_STALL = 1'b0;
    w_issue   = 1'b0;
    w_done    = 1'b0;
    pc4_d     = EXEC_PC_4;
    pcmem_d   = EXEC_PC_MEM;
    alu_d     = EXEC_ALU_RESULT;
    rfsel_d   = EXEC_RF_WR_SEL;
    regwr_d   = EXEC_REGWRITE;
    load_d    = 32'd0;
    mis_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_mem_op && w_misalign) begin
          regwr_d = 1'b0;
          mis_d   = 1'b1;
        end else if (w_mem_op) begin
          MEM_STALL = 1'b1;
          w_issue   = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (DMEM_ACK) begin
          w_done  = 1'b1;
          state_d = IDLE;
          load_d  = EXEC_MEMREAD2 ? w_load_fmt : 32'd0;
        end else begin
          MEM_STALL = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A bubble goes downstream whenever the stage is stalled.
    if (MEM_STALL) begin
      pc4_d   = 32'd0;
      pcmem_d = 32'd0;
      alu_d   = 32'd0;
      rfsel_d = 2'd0;
      regwr_d = 1'b0;
    end
  end

  // State, request registers and Memory/Writeback register.
  always_ff @(posedge MEMORY_CLOCK) begin
    if (MEMORY_RESET) begin
      state_q      <= IDLE;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      dmem_be_q    <= 4'd0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      pc4_q        <= 32'd0;
      pcmem_q      <= 32'd0;
      alu_q        <= 32'd0;
      load_q       <= 32'd0;
      rfsel_q      <= 2'd0;
      regwr_q      <= 1'b0;
      mis_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      pc4_q   <= pc4_d;
      pcmem_q <= pcmem_d;
      alu_q   <= alu_d;
      load_q  <= load_d;
      rfsel_q <= rfsel_d;
      regwr_q <= regwr_d;
      mis_q   <= mis_d;
      if (w_issue) begin
        dmem_addr_q  <= {EXEC_ALU_RESULT[31:2], 2'b00};
        dmem_wdata_q <= w_wdata;
        dmem_be_q    <= w_be;
        dmem_we_q    <= EXEC_MEMWRITE;
        dmem_req_q   <= 1'b1;
      end else if (w_done) begin
        dmem_req_q   <= 1'b0;
      end
    end
  end

  assign DMEM_ADDR      = dmem_addr_q;
  assign DMEM_WDATA     = dmem_wdata_q;
  assign DMEM_BE        = dmem_be_q;
  assign DMEM_REQ       = dmem_req_q;
  assign DMEM_WE        = dmem_we_q;
  assign MEM_PC_4       = pc4_q;
  assign MEM_PC_MEM     = pcmem_q;
  assign MEM_ALU_RESULT = alu_q;
  assign MEM_LOAD_DATA  = load_q;
  assign MEM_RF_WR_SEL  = rfsel_q;
  assign MEM_REGWRITE   = regwr_q;
  assign MEM_MISALIGN   = mis_q;

endmodule
`default_nettype wire
